// File: rtl/step_sequencer.sv
// step_sequencer: microstep counter, ALU flag register and run/pause/halt
// control that closes the decoder fetch/execute loop.
// Optional feature macro: STEP_SEQ_INSTR_COUNT_EN adds o_instr_count, a
// retired-instruction counter (absent when the macro is undefined).
module step_sequencer #(
    parameter int unsigned INSTRUCTION_STEPS = 8,
    parameter int unsigned INSTR_COUNT_WIDTH = 16,
    localparam int unsigned STEP_WIDTH = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_step_req,
    input  logic                  i_adv,
    input  logic                  i_hlt,
    input  logic                  i_el,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    input  logic                  i_alu_odd,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_odd,
    output logic                  o_cycle_en,
    output logic                  o_halted,
    output logic                  o_overrun
`ifdef STEP_SEQ_INSTR_COUNT_EN
    ,
    output logic [INSTR_COUNT_WIDTH-1:0] o_instr_count
`endif
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    // Elaboration-time parameter sanity
    if ((INSTRUCTION_STEPS < 4) || ((INSTRUCTION_STEPS & (INSTRUCTION_STEPS - 1)) != 0)) begin : g_bad_steps
        $error("INSTRUCTION_STEPS must be a power of two, at least 4");
    end
    if (INSTR_COUNT_WIDTH < 1) begin : g_bad_cnt_w
        $error("INSTR_COUNT_WIDTH must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  halted_q;
    logic                  step_req_q;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic                  odd_q, odd_d;
    logic                  overrun_q, overrun_d;
    logic                  step_edge;
    logic                  cycle_en;
    logic                  last_step;

    // Cycle enable depends only on state and the step_req edge, never on decoder bits
    always_comb begin
        step_edge = i_step_req & ~step_req_q;
        cycle_en  = 1'b0;
        case (state_q)
            ST_RUN:   cycle_en = 1'b1;
            ST_PAUSE: cycle_en = step_edge;
            default:  cycle_en = 1'b0;
        endcase
    end

    // Next microstep and flags; HLT blocks both step and flag updates
    always_comb begin
        step_d    = step_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        odd_d     = odd_q;
        overrun_d = overrun_q;
        last_step = (step_q == LAST_STEP);
        if (cycle_en && !i_hlt) begin
            if (i_adv) begin
                step_d = '0;
            end else if (last_step) begin
                step_d    = '0;
                overrun_d = 1'b1;
            end else begin
                step_d = step_q + STEP_WIDTH'(1);
            end
            if (i_el) begin
                zero_d  = i_alu_zero;
                carry_d = i_alu_carry;
                odd_d   = i_alu_odd;
            end
        end
    end

    // Run/pause/halt state machine; HALT is left only through reset
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_hlt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (!i_run) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (cycle_en && i_hlt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (i_run) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Step counter, flag and overrun registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_req_q <= 1'b0;
            step_q     <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            odd_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            step_req_q <= i_step_req;
            step_q     <= step_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            odd_q      <= odd_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef STEP_SEQ_INSTR_COUNT_EN
    logic [INSTR_COUNT_WIDTH-1:0] instr_cnt_q;
    logic                         instr_done;

    // An instruction retires on any enabled edge that returns the step to 0
    always_comb begin
        instr_done = cycle_en & ~i_hlt & (i_adv | last_step);
    end

    // Retired-instruction counter, wraps modulo 2^INSTR_COUNT_WIDTH
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            instr_cnt_q <= '0;
        end else if (instr_done) begin
            instr_cnt_q <= instr_cnt_q + INSTR_COUNT_WIDTH'(1);
        end
    end

    assign o_instr_count = instr_cnt_q;
`endif

    assign o_step     = step_q;
    assign o_zero     = zero_q;
    assign o_carry    = carry_q;
    assign o_odd      = odd_q;
    assign o_overrun  = overrun_q;
    assign o_halted   = halted_q;
    assign o_cycle_en = cycle_en;

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Microstep sequencer and ALU flag register that drives the step and flag inputs of the instruction decoder. It holds the current microstep count and latches the zero/carry/odd flags when the decoder requests it. It tracks run/pause/halt state and emits the global cycle-enable that qualifies every datapath register write. It consumes the decoder's ADV, HLT and EL control bits, which closes the fetch/execute loop.

Parameters:
INSTRUCTION_STEPS, 8, microsteps per instruction; must be a power of two, minimum 4; step width = $clog2(INSTRUCTION_STEPS)
INSTR_COUNT_WIDTH, 16, width of retired-instruction counter (used only with the optional feature)

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_run  in  1  1 = free-run; 0 = paused
i_step_req  in  1  single-step request; a rising edge in PAUSE grants one enabled cycle
i_adv  in  1  decoder ADV bit: end of instruction, next step is 0
i_hlt  in  1  decoder HLT bit
i_el  in  1  decoder EL bit: latch ALU flags
i_alu_zero  in  1  live ALU zero result
i_alu_carry  in  1  live ALU carry result
i_alu_odd  in  1  live ALU odd (bit 0) result
o_step  out  STEP_WIDTH  current microstep, feeds decoder i_step
o_zero  out  1  registered zero flag
o_carry  out  1  registered carry flag
o_odd  out  1  registered odd flag
o_cycle_en  out  1  this cycle's control word takes effect; all datapath registers gate on it
o_halted  out  1  state == HALT
o_overrun  out  1  sticky: step counter wrapped without ADV

Behaviour:
- Reset is asynchronous, active-high, on i_reset. All registers clear: state=RUN, o_step=0, flags=0, o_overrun=0, step_req edge register=0.
- States:
  - RUN: o_cycle_en=1 every cycle. If i_run=0, the next state is PAUSE; the current cycle still executes.
  - PAUSE: o_cycle_en=1 only in the cycle after a rising edge of i_step_req. The edge is detected against a registered copy of i_step_req, so holding it high yields exactly one step. If i_run=1, the next state is RUN.
  - HALT: o_cycle_en=0 permanently. o_step, flags and o_overrun are frozen. Exit only via i_reset; i_run and i_step_req are ignored.
- Step update, only when o_cycle_en=1. Priority order:
  - i_hlt: state becomes HALT, o_step holds, flags not updated, even if i_adv or i_el are also set.
  - else i_adv: o_step becomes 0.
  - else if o_step == INSTRUCTION_STEPS-1: o_step wraps to 0 and o_overrun is set.
  - else: o_step increments by 1.
- Flag update: when o_cycle_en=1, i_el=1 and i_hlt=0, all three flags load from the i_alu_* inputs on that edge. Flags are visible to the decoder from the next cycle. Otherwise flags hold.
- i_adv and i_el together: both take effect (step to 0, flags load).
- When o_cycle_en=0, every input except i_run, i_step_req and i_reset is ignored.
- Outputs are fully registered except o_cycle_en. o_cycle_en is combinational from state and the step_req edge only, never from i_adv, i_hlt or i_el, so there is no combinational loop through the decoder.
- Reset asserted mid-instruction: the sequencer returns to step 0 / RUN immediately, without waiting for a clock edge.

Optional Feature:
STEP_SEQ_INSTR_COUNT_EN:
- Defined: adds output o_instr_count [INSTR_COUNT_WIDTH-1:0], reset value 0. It increments on each enabled edge where o_step returns to 0 (ADV or wrap), wraps modulo 2^INSTR_COUNT_WIDTH, and freezes in HALT.
- Undefined: the port and counter are absent.

Test Plan:
- Reset, i_run=1, i_adv high whenever o_step==3 -> o_step cycles 0,1,2,3,0,...; o_cycle_en=1 every cycle; o_overrun stays 0.
- i_adv never asserted, INSTRUCTION_STEPS=8 -> o_step counts 0..7 then 0; o_overrun=1 from the edge after step 7 and remains set.
- At step 4: i_el=1, alu zero=1, carry=1, odd=0 -> next cycle o_zero=1, o_carry=1, o_odd=0. Same stimulus with i_el=0 -> flags unchanged.
- At step 2: i_hlt=1 together with i_adv=1 and i_el=1 -> o_halted=1, o_step stays 2, flags unchanged, o_cycle_en=0; i_run and i_step_req toggles have no effect until i_reset.
- i_run=0 -> PAUSE, o_step frozen; i_step_req held high 5 cycles -> exactly one o_cycle_en pulse and o_step +1; i_run=1 -> counting resumes.
- Assert i_reset asynchronously at step 5 with flags set -> o_step=0 and flags=0 before the next clock edge; with STEP_SEQ_INSTR_COUNT_EN, 3 completed instructions -> o_instr_count=3.
